// File: rtl/muldiv_pkg.sv
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP_A,
    S_PREP_B,
    S_ITER,
    S_FIX1,
    S_FIX2,
    S_FIX3
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  state_t           state,
  input  logic             is_div,
  input  logic             neg_a,
  input  logic             neg_b,
  input  logic             lo_nz,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] m_nxt,
  output logic             lo_nz_nxt
);

  logic             neg;
  logic [WIDTH-1:0] sh;
  logic             carry;
  logic             take;

  assign neg = neg_a ^ neg_b;
  assign sh  = {hi[WIDTH-2:0], lo[WIDTH-1]};

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = '0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    m_nxt     = m;
    lo_nz_nxt = lo_nz;
    carry     = 1'b0;
    take      = 1'b0;
    unique case (state)
      S_PREP_A: begin
        alu_b    = lo;
        alu_ctrl = ALU_SUBU;
        if (neg_a) lo_nxt = alu_y;
      end
      S_PREP_B: begin
        alu_b    = m;
        alu_ctrl = ALU_SUBU;
        if (neg_b) m_nxt = alu_y;
      end
      S_ITER: begin
        if (!is_div) begin
          alu_a    = hi;
          alu_b    = lo[0] ? m : '0;
          alu_ctrl = ALU_ADDU;
          // the ALU has no carry-out; a wrapped sum is smaller than hi
          carry    = (alu_y < hi);
          {hi_nxt, lo_nxt} = {carry, alu_y, lo[WIDTH-1:1]};
        end else begin
          alu_a    = sh;
          alu_b    = m;
          alu_ctrl = ALU_SUBU;
          // hi[WIDTH-1] is the bit shifted out of sh: remainder already exceeds m
          take     = hi[WIDTH-1] | (sh >= m);
          hi_nxt   = take ? alu_y : sh;
          lo_nxt   = {lo[WIDTH-2:0], take};
        end
      end
      S_FIX1: begin
        alu_b    = lo;
        alu_ctrl = ALU_SUBU;
        if (!is_div) lo_nz_nxt = (lo != '0);
        if (neg) lo_nxt = alu_y;
      end
      S_FIX2: begin
        alu_b    = hi;
        alu_ctrl = ALU_SUBU;
        if (is_div ? neg_a : neg) hi_nxt = alu_y;
      end
      S_FIX3: begin
        // 64-bit negate of the product: borrow into hi unless lo was zero
        if (!is_div) begin
          alu_a    = hi;
          alu_b    = WIDTH'(1);
          alu_ctrl = ALU_SUBU;
          if (neg && lo_nz) hi_nxt = alu_y;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_y
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             done_nxt;

  logic [WIDTH-1:0] m;
  logic             is_div, sgn, neg_a, neg_b, lo_nz;
  logic [WIDTH-1:0] hi_nxt, lo_nxt, m_nxt;
  logic             lo_nz_nxt;

  assign busy    = (state != S_IDLE);
  assign alu_req = busy;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .state     (state),
    .is_div    (is_div),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .lo_nz     (lo_nz),
    .hi        (hi),
    .lo        (lo),
    .m         (m),
    .alu_y     (alu_y),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .hi_nxt    (hi_nxt),
    .lo_nxt    (lo_nxt),
    .m_nxt     (m_nxt),
    .lo_nz_nxt (lo_nz_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = op_is_signed(op) ? S_PREP_A : S_ITER;
          count_nxt = '0;
        end
      end
      S_PREP_A: if (alu_gnt) state_nxt = S_PREP_B;
      S_PREP_B: if (alu_gnt) state_nxt = S_ITER;
      S_ITER: begin
        if (alu_gnt) begin
          if (count == CNT_W'(WIDTH - 1)) begin
            if (sgn) begin
              state_nxt = S_FIX1;
            end else begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      S_FIX1: if (alu_gnt) state_nxt = S_FIX2;
      S_FIX2: if (alu_gnt) state_nxt = S_FIX3;
      S_FIX3: begin
        if (alu_gnt) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      is_div <= 1'b0;
      sgn    <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      lo_nz  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        m      <= b;
        lo     <= a;
        hi     <= '0;
        is_div <= op_is_div(op);
        sgn    <= op_is_signed(op);
        neg_a  <= a[WIDTH-1] & op_is_signed(op);
        neg_b  <= b[WIDTH-1] & op_is_signed(op);
        lo_nz  <= 1'b0;
      end else begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end else if (alu_gnt) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      m     <= m_nxt;
      lo_nz <= lo_nz_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we, alu_gnt;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, alu_y;
  logic        busy, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b;
  logic [3:0]  alu_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared ALU; returns junk when not granted so a sequencer that uses
  // an ungranted result is caught.
  always_comb begin
    if (!alu_gnt)                   alu_y = 32'hA5A5_A5A5;
    else if (alu_ctrl == ALU_ADDU)  alu_y = alu_a + alu_b;
    else if (alu_ctrl == ALU_SUBU)  alu_y = alu_a - alu_b;
    else                            alu_y = 32'h5A5A_5A5A;
  end

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_y    (alu_y)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result: {hi, lo}
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [31:0] ux, uy, q, r;
    logic        nx, ny;
    if (!o[0]) begin
      if (o[1]) begin
        sx = $signed(x);
        sy = $signed(y);
        return 64'(sx * sy);
      end
      return {32'h0, x} * {32'h0, y};
    end
    nx = o[1] & x[31];
    ny = o[1] & y[31];
    ux = nx ? -x : x;
    uy = ny ? -y : y;
    if (uy == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = ux;
    end else begin
      q = ux / uy;
      r = ux % uy;
    end
    if (nx ^ ny) q = -q;
    if (nx) r = -r;
    return {r, q};
  endfunction

  // Cycle-level model: count granted busy cycles, publish result at the end.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          rem = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      rem    <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          rem    <= op[1] ? 37 : 32;
          {p_hi, p_lo} <= ref_result(op, a, b);
        end else begin
          if (hi_we) m_hi <= wdata;
          if (lo_we) m_lo <= wdata;
        end
      end else if (alu_gnt) begin
        if (rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= p_hi;
          m_lo   <= p_lo;
        end
        rem <= rem - 1;
      end
    end
  end

  logic        mon_en = 1'b0;
  logic        pv_busy = 1'b0, pv_gnt = 1'b1;
  logic [31:0] pv_a = '0, pv_b = '0;
  logic [3:0]  pv_ctrl = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("alu_req", alu_req, m_busy);
      if (!m_busy) begin
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
      end
      if (pv_busy && !pv_gnt && busy) begin
        chk("hold_alu_a", alu_a, pv_a);
        chk("hold_alu_b", alu_b, pv_b);
        chk("hold_alu_ctrl", alu_ctrl, pv_ctrl);
      end
    end
    pv_busy <= busy;
    pv_gnt  <= alu_gnt;
    pv_a    <= alu_a;
    pv_b    <= alu_b;
    pv_ctrl <= alu_ctrl;
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit toggle, input int abort_at, input bit inject,
                        output int lat, output int nbusy, output int ndeny);
    bit fin;
    fin   = 1'b0;
    lat   = 0;
    nbusy = 0;
    ndeny = 0;
    @(posedge clk); #2;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    while (!fin && lat < 200) begin
      @(posedge clk); #2;
      start   = 1'b0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      alu_gnt = toggle ? (lat % 2 == 0) : 1'b1;
      if (inject && lat == 4) begin
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'h0000_0050;
        b     = 32'h0000_0003;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      lat++;
      if (busy) begin
        nbusy++;
        if (!alu_gnt) ndeny++;
      end
      if (done) fin = 1'b1;
      if (abort_at != 0 && lat == abort_at) begin
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
        end
        fin = 1'b1;
      end
    end
    chk("op_finished", fin, 1);
    @(posedge clk); #2;
    alu_gnt = 1'b1;
  endtask

  int lat, nb, nd;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; alu_gnt = 1'b1;
    @(posedge clk); #2;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_alu_req", alu_req, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #2;
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h1234_5678);
    hi_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #2;
    hi_we = 1'b0;
    chk("mthi", hi, 32'h0BAD_F00D);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, lat, nb, nd);
    chk("multu_lat", lat, 33);
    chk("multu_busy_cycles", nb, 32);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0, 0, lat, nb, nd);
    chk("mult_lat", lat, 38);
    chk("mult_busy_cycles", nb, 37);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, lat, nb, nd);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0000_0000);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0, lat, nb, nd);
    chk("div_lat", lat, 38);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0, 0, 0, lat, nb, nd);
    chk("div_negb_lo", lo, 32'hFFFF_FFF2);
    chk("div_negb_hi", hi, 32'h0000_0002);

    run_op(OP_DIVU, 32'd100, 32'd0, 0, 0, 0, lat, nb, nd);
    chk("divu0_lat", lat, 33);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_0064);

    run_op(OP_DIV, 32'hFFFF_FFF8, 32'd0, 0, 0, 0, lat, nb, nd);
    chk("div0_lo", lo, 32'h0000_0001);
    chk("div0_hi", hi, 32'hFFFF_FFF8);

    run_op(OP_DIVU, 32'd1000, 32'd7, 1, 0, 0, lat, nb, nd);
    chk("divu_tog_lo", lo, 32'h0000_008E);
    chk("divu_tog_hi", hi, 32'h0000_0006);
    chk("divu_tog_denied", nd, 31);
    chk("divu_tog_lat", lat, 64);
    chk("divu_tog_lat_vs_denied", lat, 33 + nd);

    run_op(OP_MULTU, 32'h0001_0003, 32'h0000_0777, 0, 10, 0, lat, nb, nd);

    run_op(OP_MULTU, 32'd6, 32'd7, 0, 0, 0, lat, nb, nd);
    chk("multu67_lo", lo, 32'h0000_002A);
    chk("multu67_hi", hi, 32'h0000_0000);

    run_op(OP_MULTU, 32'h0001_2345, 32'h0000_0100, 0, 0, 1, lat, nb, nd);
    chk("inject_lat", lat, 33);
    chk("inject_lo", lo, 32'h0123_4500);
    chk("inject_hi", hi, 32'h0000_0000);

    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
